// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N stream demultiplexer with valid/ready
// handshakes. Each channel owns a one-entry output register, so a stalled
// consumer only blocks traffic addressed to it. Supports broadcast to all
// channels and counts (saturating) words whose select is out of range.
module demux_stream #(
    parameter int DATA_W = 4,
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                     inClk,
    input  logic                     inRst_n,
    input  logic [DATA_W-1:0]        inData,
    input  logic [SEL_W-1:0]         inSel,
    input  logic                     inBcast,
    input  logic                     inValid,
    output logic                     outReady,
    output logic [N_CH*DATA_W-1:0]   outData,
    output logic [N_CH-1:0]          outValid,
    input  logic [N_CH-1:0]          inReady,
    output logic [CNT_W-1:0]         outDropCnt,
    input  logic                     inDropClr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_CH-1:0]              valid_q, valid_d;
    logic [N_CH-1:0][DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic [N_CH-1:0]              ch_free;
    logic [N_CH-1:0]              wr_en;
    logic                         sel_in_range;
    logic                         sel_free;
    logic                         accept;
    logic                         drop;

    // Input-side readiness: a channel is free when empty or draining this cycle.
    // Out-of-range words are always taken so they never stall the source.
    always_comb begin
        sel_in_range = (32'(inSel) < 32'(N_CH));
        ch_free      = ~valid_q | inReady;
        sel_free     = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (32'(inSel) == 32'(k)) begin
                sel_free = ch_free[k];
            end
        end

        if (!inRst_n) begin
            outReady = 1'b0;
        end else if (inBcast) begin
            outReady = &ch_free;
        end else if (sel_in_range) begin
            outReady = sel_free;
        end else begin
            outReady = 1'b1;
        end

        accept = inValid & outReady;
        drop   = accept & ~inBcast & ~sel_in_range;
    end

    // Per-channel next state: a write wins over a simultaneous drain.
    always_comb begin
        wr_en  = '0;
        data_d = data_q;
        for (int k = 0; k < N_CH; k++) begin
            wr_en[k] = accept & (inBcast | (sel_in_range & (32'(inSel) == 32'(k))));
            if (wr_en[k]) begin
                data_d[k] = inData;
            end
        end
        valid_d = wr_en | (valid_q & ~inReady);
    end

    // Drop counter: clear has priority, increments saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inDropClr) begin
            cnt_d = '0;
        end else if (drop && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers; reset discards any pending words immediately.
    always_ff @(posedge inClk or negedge inRst_n) begin
        if (!inRst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outValid   = valid_q;
    assign outData    = data_q;
    assign outDropCnt = cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed scenarios plus a randomized run checked
// against a per-channel behavioural model. A second instance with a 2-bit
// drop counter and 6 channels exercises out-of-range drops and saturation.
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // main instance: DATA_W=4, N_CH=8, SEL_W=3, CNT_W=8
    logic [3:0]  in_data = '0;
    logic [2:0]  in_sel = '0;
    logic        in_bcast = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  in_ready = '0;
    logic [7:0]  out_cnt;
    logic        in_clr = 1'b0;

    // small instance: DATA_W=4, N_CH=6, SEL_W=3, CNT_W=2
    logic [3:0]  s_data = '0;
    logic [2:0]  s_sel = '0;
    logic        s_bcast = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_out_ready;
    logic [23:0] s_out_data;
    logic [5:0]  s_out_valid;
    logic [5:0]  s_ready = '0;
    logic [1:0]  s_cnt;
    logic        s_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_stream #(.DATA_W(4), .N_CH(8), .SEL_W(3), .CNT_W(8)) u_dut (
        .inClk(clk), .inRst_n(rst_n), .inData(in_data), .inSel(in_sel),
        .inBcast(in_bcast), .inValid(in_valid), .outReady(out_ready),
        .outData(out_data), .outValid(out_valid), .inReady(in_ready),
        .outDropCnt(out_cnt), .inDropClr(in_clr)
    );

    demux_stream #(.DATA_W(4), .N_CH(6), .SEL_W(3), .CNT_W(2)) u_sat (
        .inClk(clk), .inRst_n(rst_n), .inData(s_data), .inSel(s_sel),
        .inBcast(s_bcast), .inValid(s_valid), .outReady(s_out_ready),
        .outData(s_out_data), .outValid(s_out_valid), .inReady(s_ready),
        .outDropCnt(s_cnt), .inDropClr(s_clr)
    );

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_low: got %b want 0", out_ready);
        end
        rst_n = 1'b1;
        edge1();
        total++;
        if (out_valid !== 8'h00 || out_cnt !== 8'd0 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_idle: valid=%h cnt=%0d data=%h want 00/0/0",
                     out_valid, out_cnt, out_data);
        end
        total++;
        if (out_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_high: got %b want 1", out_ready);
        end
        total++;
        if (s_out_valid !== 6'h0 || s_cnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_small: valid=%h cnt=%0d want 0/0", s_out_valid, s_cnt);
        end
    endtask

    task automatic test_sweep();
        in_ready = 8'hFF;
        in_bcast = 1'b0;
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            in_data = 4'(s + 1);
            in_valid = 1'b1;
            edge1();
            total++;
            if (out_valid !== 8'(1 << s) || out_data[s*4 +: 4] !== 4'(s + 1)) begin
                bad++;
                $display("FAIL sweep_ch%0d: valid=%h data=%h want %h/%h",
                         s, out_valid, out_data[s*4 +: 4], 8'(1 << s), 4'(s + 1));
            end
        end
        in_valid = 1'b0;
        edge1();
        total++;
        if (out_valid !== 8'h00) begin
            bad++;
            $display("FAIL sweep_drain: valid=%h want 00", out_valid);
        end
    endtask

    task automatic test_backpressure();
        in_ready = 8'hF7;
        in_bcast = 1'b0;
        in_sel = 3'd3;
        in_data = 4'hA;
        in_valid = 1'b1;
        #1;
        total++;
        if (out_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_first_ready: got %b want 1", out_ready);
        end
        edge1();
        total++;
        if (out_valid[3] !== 1'b1 || out_data[12 +: 4] !== 4'hA) begin
            bad++;
            $display("FAIL bp_first_word: v=%b d=%h want 1/a", out_valid[3], out_data[12 +: 4]);
        end
        in_data = 4'hB;
        #1;
        total++;
        if (out_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall_ready: got %b want 0", out_ready);
        end
        edge1();
        total++;
        if (out_valid[3] !== 1'b1 || out_data[12 +: 4] !== 4'hA) begin
            bad++;
            $display("FAIL bp_hold: v=%b d=%h want 1/a", out_valid[3], out_data[12 +: 4]);
        end
        // channel 5 flows while channel 3 is stalled
        in_sel = 3'd5;
        in_data = 4'hC;
        #1;
        total++;
        if (out_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ch5_ready: got %b want 1", out_ready);
        end
        edge1();
        total++;
        if (out_valid !== 8'h28 || out_data[20 +: 4] !== 4'hC || out_data[12 +: 4] !== 4'hA) begin
            bad++;
            $display("FAIL bp_ch5_flow: valid=%h d5=%h d3=%h want 28/c/a",
                     out_valid, out_data[20 +: 4], out_data[12 +: 4]);
        end
        // release channel 3: drain and write of B in the same cycle
        in_sel = 3'd3;
        in_data = 4'hB;
        in_ready = 8'hFF;
        #1;
        total++;
        if (out_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %b want 1", out_ready);
        end
        edge1();
        total++;
        if (out_valid !== 8'h08 || out_data[12 +: 4] !== 4'hB) begin
            bad++;
            $display("FAIL bp_second_word: valid=%h d3=%h want 08/b", out_valid, out_data[12 +: 4]);
        end
        in_valid = 1'b0;
        edge1();
        total++;
        if (out_valid !== 8'h00 || out_data[12 +: 4] !== 4'hB) begin
            bad++;
            $display("FAIL bp_final_drain: valid=%h d3=%h want 00/b", out_valid, out_data[12 +: 4]);
        end
    endtask

    task automatic test_broadcast();
        in_ready = 8'hFF;
        in_bcast = 1'b1;
        in_data = 4'h5;
        in_valid = 1'b1;
        #1;
        total++;
        if (out_ready !== 1'b1) begin
            bad++;
            $display("FAIL bcast_ready: got %b want 1", out_ready);
        end
        edge1();
        total++;
        if (out_valid !== 8'hFF || out_data !== 32'h5555_5555) begin
            bad++;
            $display("FAIL bcast_all: valid=%h data=%h want ff/55555555", out_valid, out_data);
        end
        // channel 6 held busy; others drain this cycle, broadcast must wait
        in_ready = 8'hBF;
        in_data = 4'h9;
        #1;
        total++;
        if (out_ready !== 1'b0) begin
            bad++;
            $display("FAIL bcast_blocked_ready: got %b want 0", out_ready);
        end
        edge1();
        total++;
        if (out_valid !== 8'h40 || out_data !== 32'h5555_5555) begin
            bad++;
            $display("FAIL bcast_no_partial: valid=%h data=%h want 40/55555555", out_valid, out_data);
        end
        in_valid = 1'b0;
        in_bcast = 1'b0;
        in_ready = 8'hFF;
        edge1();
    endtask

    task automatic test_drop_saturation();
        s_valid = 1'b1;
        s_sel = 3'd7;
        s_ready = '0;
        s_data = 4'h3;
        for (int i = 0; i < 5; i++) begin
            s_sel = (i == 2) ? 3'd6 : 3'd7;
            #1;
            total++;
            if (s_out_ready !== 1'b1) begin
                bad++;
                $display("FAIL drop_ready_%0d: got %b want 1", i, s_out_ready);
            end
            edge1();
            total++;
            if (s_cnt !== 2'((i + 1 > 3) ? 3 : i + 1) || s_out_valid !== 6'h0) begin
                bad++;
                $display("FAIL drop_count_%0d: cnt=%0d valid=%h want %0d/00",
                         i, s_cnt, s_out_valid, (i + 1 > 3) ? 3 : i + 1);
            end
        end
        s_clr = 1'b1;
        edge1();
        total++;
        if (s_cnt !== 2'd0) begin
            bad++;
            $display("FAIL drop_clear_wins: cnt=%0d want 0", s_cnt);
        end
        s_clr = 1'b0;
        s_valid = 1'b0;
        edge1();
    endtask

    task automatic test_random();
        bit       mv [8];
        bit [3:0] md [8];
        bit       exp_rdy;
        bit       acc;
        bit [7:0] exp_v;
        int       errs;
        // start from a known empty state
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        edge1();
        for (int k = 0; k < 8; k++) begin
            mv[k] = 1'b0;
            md[k] = 4'h0;
        end
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_bcast = ($urandom_range(0, 7) == 0);
            in_sel = 3'($urandom_range(0, 7));
            in_data = 4'($urandom);
            in_ready = 8'($urandom);
            #1;
            if (in_bcast) begin
                exp_rdy = 1'b1;
                for (int k = 0; k < 8; k++) exp_rdy &= (!mv[k] || in_ready[k]);
            end else begin
                exp_rdy = !mv[in_sel] || in_ready[in_sel];
            end
            total++;
            if (out_ready !== exp_rdy) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL rand_ready n=%0d: got %b want %b", n, out_ready, exp_rdy);
            end
            acc = in_valid && exp_rdy;
            for (int k = 0; k < 8; k++) begin
                if (acc && (in_bcast || int'(in_sel) == k)) begin
                    mv[k] = 1'b1;
                    md[k] = in_data;
                end else if (mv[k] && in_ready[k]) begin
                    mv[k] = 1'b0;
                end
            end
            edge1();
            for (int k = 0; k < 8; k++) exp_v[k] = mv[k];
            total++;
            if (out_valid !== exp_v) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL rand_valid n=%0d: got %h want %h", n, out_valid, exp_v);
            end
            for (int k = 0; k < 8; k++) begin
                total++;
                if (out_data[k*4 +: 4] !== md[k]) begin
                    bad++;
                    errs++;
                    if (errs < 10) $display("FAIL rand_data n=%0d ch%0d: got %h want %h",
                                            n, k, out_data[k*4 +: 4], md[k]);
                end
            end
        end
        in_valid = 1'b0;
        in_bcast = 1'b0;
        in_ready = 8'hFF;
        edge1();
    endtask

    task automatic test_async_reset();
        in_ready = 8'h00;
        in_bcast = 1'b0;
        in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 3'(s);
            in_data = 4'(s + 8);
            edge1();
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 8'h0F) begin
            bad++;
            $display("FAIL arst_setup: valid=%h want 0f", out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 8'h00 || out_data !== 32'h0 || out_ready !== 1'b0) begin
            bad++;
            $display("FAIL arst_immediate: valid=%h data=%h ready=%b want 00/0/0",
                     out_valid, out_data, out_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        edge1();
        total++;
        if (out_valid !== 8'h00) begin
            bad++;
            $display("FAIL arst_after_release: valid=%h want 00", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_broadcast();
        test_drop_saturation();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
